multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS-subset datapath. Each instruction is split into fetch, decode, execute, memory and writeback steps, so one ALU and one unified memory port are shared across cycles instead of duplicated. Sits between the instruction register (IR) and the datapath muxes/enables. Supports add, sub, and, or, xor, lw, sw, beq and lui. Stalls on a memory ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]; stable from the cycle after IR is written
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational in the current cycle
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_write  out  1  request is a store
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch memory read data into IR
- pc_write  out  1  PC load enable
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  3  ALU function: 000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-data select: 1 = MDR, 0 = ALUOut
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky; set on an unsupported op or func
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W
- state  out  4  current state encoding, for debug

## Operation
State encodings: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_LD=6, MEM_WR=7, BRANCH=8, EXEC_LUI=9, WB_LUI=10, HALT=11.

Outputs are decoded from state, plus mem_ready (FETCH, MEM_RD, MEM_WR) and zero (BRANCH). Any output not listed for a state is 0.

- **FETCH:** mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - While mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=000, which precomputes the branch target into ALUOut. Next state by op:
  - 000000 → EXEC_R if func is in {100000, 100010, 100100, 100101, 100110}, else HALT.
  - 100011 or 101011 → ADDR.
  - 000100 → BRANCH.
  - 001111 → EXEC_LUI.
  - Any other op → HALT.
- **EXEC_R:** alu_src_a=1, alu_src_b=00. alu_op by func: 100000→000, 100010→100, 100100→001, 100101→101, 100110→010. Next state is WB_R.
- **WB_R:** reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
- **ADDR:** alu_src_a=1, alu_src_b=10, alu_op=000. Next state is MEM_RD if op=100011, else MEM_WR.
- **MEM_RD:** mem_req=1, iord=1. Moves to WB_LD when mem_ready=1.
- **WB_LD:** reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state is FETCH.
- **MEM_WR:** mem_req=1, mem_write=1, iord=1. When mem_ready=1: instr_done=1 and next state is FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=100, pc_src=1, pc_write=zero, instr_done=1. Next state is FETCH.
- **EXEC_LUI:** alu_src_b=10, alu_op=110. Next state is WB_LUI.
- **WB_LUI:** reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- **HALT:** all outputs 0 except illegal=1. The FSM stays in HALT until rst. illegal is set on the DECODE→HALT edge.
- **retired:** increments on every cycle with instr_done=1. All-ones wraps to 0.

## Timing
- Reset: on a clock edge with rst=1, state←FETCH, illegal←0 and retired←0.
- While rst=1, every combinational output is forced to 0, including mem_req.
- The first cycle after rst deasserts is FETCH with mem_req=1.
- rst wins over every other condition. Asserting it mid-instruction (for example in MEM_WR with mem_req high) drops mem_req in the same cycle, and no writes occur.
- mem_req, iord and mem_write are held constant until the cycle in which mem_ready=1. mem_ready is ignored in states that do not request memory.
- Latency with mem_ready tied to 1:

  | Instruction | Cycles, fetch to instr_done |
  |---|---|
  | R-type | 4 |
  | lw | 5 |
  | sw | 4 |
  | lui | 4 |
  | beq | 3 |

- Each wait cycle on a memory access adds one cycle.
- A new FETCH follows instr_done in the next cycle; there are no idle cycles between instructions.

## Test plan
- **Reset:** hold rst for 3 cycles with mem_ready=1 → all outputs 0 during reset; then state=0, mem_req=1, retired=0.
- **add:** op=000000, func=100000, mem_ready=1 → state sequence 0,1,2,3; in EXEC_R alu_op=000; in WB_R reg_write=1 and reg_dst=1; instr_done pulses once and retired=1.
- **lw with waits:** op=100011, mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD → completes in 10 cycles; ir_write and pc_write pulse only on the fetch ready cycle; WB_LD has mem_to_reg=1.
- **beq:** op=000100, once with zero=1 and once with zero=0 → pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; 3 cycles each.
- **Illegal decode:** op=111111, then separately op=000000 with func=101010 → state=11, illegal=1, outputs stay 0 indefinitely; rst clears illegal.
- **Reset mid-store and counter wrap:** with CNT_W=4, retire 16 instructions → retired wraps 15→0; assert rst in MEM_WR with mem_ready=0 → mem_req and mem_write drop that cycle, and state=FETCH after the edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset datapath.
// Shares one ALU and one memory port across fetch/decode/exec/mem/wb.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        ADDR     = 4'd4,
        MEM_RD   = 4'd5,
        WB_LD    = 4'd6,
        MEM_WR   = 4'd7,
        BRANCH   = 4'd8,
        EXEC_LUI = 4'd9,
        WB_LUI   = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LUI = 6'b001111;

    state_t           cur;
    state_t           nxt;
    logic             illegal_r;
    logic [CNT_W-1:0] cnt;
    logic             func_ok;
    logic [2:0]       r_alu_op;

    assign state   = cur;
    assign illegal = illegal_r;
    assign retired = cnt;

    // Map R-type func to ALU operation and flag unsupported encodings
    always_comb begin
        func_ok  = 1'b1;
        r_alu_op = 3'b000;
        case (func)
            6'b100000: r_alu_op = 3'b000;
            6'b100010: r_alu_op = 3'b100;
            6'b100100: r_alu_op = 3'b001;
            6'b100101: r_alu_op = 3'b101;
            6'b100110: r_alu_op = 3'b010;
            default:   func_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // Sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_r <= 1'b0;
            cnt       <= '0;
        end else begin
            if (cur == DECODE && nxt == HALT) illegal_r <= 1'b1;
            if (instr_done) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and datapath control decode; reset forces all controls low
    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_R:         nxt = func_ok ? EXEC_R : HALT;
                    OP_LW, OP_SW: nxt = ADDR;
                    OP_BEQ:       nxt = BRANCH;
                    OP_LUI:       nxt = EXEC_LUI;
                    default:      nxt = HALT;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
                nxt       = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = WB_LD;
            end
            WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b100;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            EXEC_LUI: begin
                alu_src_b = 2'b10;
                alu_op    = 3'b110;
                nxt       = WB_LUI;
            end
            WB_LUI: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 3'b000;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control
// vectors are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
        logic [3:0] retired;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, iord, ir_write, pc_write, pc_src;
    logic       alu_src_a, reg_dst, reg_write, mem_to_reg, instr_done;
    logic       illegal;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] retired;
    logic [3:0] st;

    int   errors = 0;
    int   checks = 0;
    logic [3:0] exp_ret = 4'd0;
    logic       exp_ill = 1'b0;
    exp_t sb[$];
    exp_t act;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .illegal(illegal), .retired(retired), .state(st)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '{st, mem_req, mem_write, iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_dst, reg_write,
                mem_to_reg, instr_done, illegal, retired};
    end

    task automatic check(input string tag, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Compare the control vector of each cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("st%0d@%0t", e.st, $time), act, e);
        end
    end

    function automatic exp_t base(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        e.illegal = exp_ill;
        e.retired = exp_ret;
        return e;
    endfunction

    task automatic step(input exp_t e, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (e.instr_done) exp_ret++;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_ret = 4'd0;
        exp_ill = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = '0;
            step(e, 1'b1, 1'b1);
        end
        rst = 1'b0;
    endtask

    task automatic fetch(input int waits);
        exp_t e;
        e = base(4'd0);
        e.mem_req = 1'b1;
        e.alu_src_b = 2'b01;
        for (int i = 0; i < waits; i++) step(e, 1'b0, 1'b0);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        step(e, 1'b1, 1'b0);
        e = base(4'd1);
        e.alu_src_b = 2'b11;
        step(e, 1'b0, 1'b1);
    endtask

    task automatic r_type(input logic [5:0] f, input logic [2:0] aop);
        exp_t e;
        op = 6'b000000;
        func = f;
        fetch(0);
        e = base(4'd2);
        e.alu_src_a = 1'b1;
        e.alu_op = aop;
        step(e, 1'b0, 1'b0);
        e = base(4'd3);
        e.reg_write = 1'b1;
        e.reg_dst = 1'b1;
        e.instr_done = 1'b1;
        step(e, 1'b0, 1'b0);
    endtask

    task automatic addr_step();
        exp_t e;
        e = base(4'd4);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        step(e, 1'b0, 1'b0);
    endtask

    task automatic lw(input int wf, input int wm);
        exp_t e;
        op = 6'b100011;
        func = 6'h15;
        fetch(wf);
        addr_step();
        e = base(4'd5);
        e.mem_req = 1'b1;
        e.iord = 1'b1;
        for (int i = 0; i < wm; i++) step(e, 1'b0, 1'b0);
        step(e, 1'b1, 1'b0);
        e = base(4'd6);
        e.reg_write = 1'b1;
        e.mem_to_reg = 1'b1;
        e.instr_done = 1'b1;
        step(e, 1'b0, 1'b0);
    endtask

    task automatic sw();
        exp_t e;
        op = 6'b101011;
        fetch(0);
        addr_step();
        e = base(4'd7);
        e.mem_req = 1'b1;
        e.mem_write = 1'b1;
        e.iord = 1'b1;
        step(e, 1'b0, 1'b0);
        e.instr_done = 1'b1;
        step(e, 1'b1, 1'b0);
    endtask

    task automatic beq(input logic z);
        exp_t e;
        op = 6'b000100;
        fetch(0);
        e = base(4'd8);
        e.alu_src_a = 1'b1;
        e.alu_op = 3'b100;
        e.pc_src = 1'b1;
        e.pc_write = z;
        e.instr_done = 1'b1;
        step(e, 1'b1, z);
    endtask

    task automatic lui();
        exp_t e;
        op = 6'b001111;
        fetch(0);
        e = base(4'd9);
        e.alu_src_b = 2'b10;
        e.alu_op = 3'b110;
        step(e, 1'b0, 1'b0);
        e = base(4'd10);
        e.reg_write = 1'b1;
        e.instr_done = 1'b1;
        step(e, 1'b0, 1'b0);
    endtask

    task automatic bad(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        op = o;
        func = f;
        fetch(0);
        exp_ill = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = base(4'd11);
            step(e, i[0], ~i[0]);
        end
    endtask

    initial begin
        exp_t e;
        do_reset(3);
        r_type(6'b100000, 3'b000);
        lw(2, 3);
        beq(1'b1);
        beq(1'b0);
        r_type(6'b100010, 3'b100);
        r_type(6'b100100, 3'b001);
        r_type(6'b100101, 3'b101);
        r_type(6'b100110, 3'b010);
        sw();
        lui();
        for (int i = 0; i < 7; i++) begin
            case ($urandom_range(0, 2))
                0:       lui();
                1:       sw();
                default: r_type(6'b100000, 3'b000);
            endcase
        end
        op = 6'b101011;
        fetch(0);
        addr_step();
        e = base(4'd7);
        e.mem_req = 1'b1;
        e.mem_write = 1'b1;
        e.iord = 1'b1;
        step(e, 1'b0, 1'b0);
        rst = 1'b1;
        e = base(4'd7);
        step(e, 1'b0, 1'b0);
        rst = 1'b0;
        exp_ret = 4'd0;
        exp_ill = 1'b0;
        sw();
        bad(6'b111111, 6'b100000);
        do_reset(2);
        bad(6'b000000, 6'b101010);
        do_reset(1);
        r_type(6'b100000, 3'b000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
